detection_event_monitor: RTL and testbench

- Downstream consumer of the 11011 Moore sequence detector. Its Z output feeds this block's Z input.
- Counts distinct detection events over fixed windows of WINDOW clock cycles.
- At the end of each window it snapshots the count and presents it on a VALID/ACK readout handshake.
- Flags a threshold ALARM, and flags OVERRUN when an unacknowledged result is overwritten.

---
 rtl/detection_monitor_pkg.sv | 14 +
 rtl/detection_event_monitor_window_timer.sv | 37 +++
 rtl/detection_event_monitor.sv | 112 +++++++++++
 tb/tb_detection_event_monitor.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/detection_monitor_pkg.sv
// Shared types and default sizing for the detection event monitor.
// DETECTION_MONITOR_SATURATE_EN selects saturating counters in the top.
package detection_monitor_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_WINDOW = 64;
  localparam int DEF_THRESH = 4;

endpackage

// File: rtl/detection_event_monitor_window_timer.sv
// Window cycle counter with a one-cycle strobe on the last window cycle.
// Restarts from zero whenever CLR is high or the monitor is not running.
module window_timer
  import detection_monitor_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic run_i,
  output logic win_end_o
);

  localparam int WW = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WW-1:0] LAST = WW'(WINDOW - 1);

  logic [WW-1:0] win_cnt_q, win_cnt_d;

  assign win_end_o = run_i && (win_cnt_q == LAST);

  always_comb begin
    win_cnt_d = win_cnt_q + 1'b1;
    if (clr_i || !run_i || win_end_o) begin
      win_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_cnt_q <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
    end
  end

endmodule

// File: rtl/detection_event_monitor.sv
// Counts rising edges of Z per window and reports them over VALID/ACK.
// Define DETECTION_MONITOR_SATURATE_EN for saturating event counts.
module detection_event_monitor
  import detection_monitor_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int WINDOW = DEF_WINDOW,
  parameter int THRESH = DEF_THRESH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Z,
  input  logic             EN,
  input  logic             CLR,
  input  logic             ACK,
  output logic [CNT_W-1:0] CNT_OUT,
  output logic             VALID,
  output logic             ALARM,
  output logic             OVERRUN,
  output logic             BUSY
);

  state_e           state_q, state_d;
  logic             z_q;
  logic [CNT_W-1:0] evt_q, evt_d, evt_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             alarm_q, alarm_d;
  logic             ovr_q, ovr_d;
  logic             run, evt, win_end, sat_win;

  assign run = (state_q == RUN) && EN;
  assign evt = Z && !z_q;

  window_timer #(
    .WINDOW(WINDOW)
  ) u_timer (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .clr_i    (CLR),
    .run_i    (run),
    .win_end_o(win_end)
  );

`ifdef DETECTION_MONITOR_SATURATE_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic sat_q, sat_d, inc_sat;

  assign inc_sat = evt && (evt_q == CNT_MAX);
  assign evt_nx  = inc_sat ? CNT_MAX : evt_q + CNT_W'(evt);
  assign sat_win = sat_q || inc_sat;
  assign sat_d   = (CLR || !run || win_end) ? 1'b0 : sat_win;

  always_ff @(posedge CLK) begin
    if (!RESET) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
`else
  assign evt_nx  = evt_q + CNT_W'(evt);
  assign sat_win = 1'b0;
`endif

  always_comb begin
    state_d = EN ? RUN : IDLE;
    evt_d   = (CLR || !run || win_end) ? '0 : evt_nx;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    alarm_d = alarm_q;
    ovr_d   = ovr_q;
    if (CLR) begin
      cnt_d   = '0;
      valid_d = 1'b0;
      alarm_d = 1'b0;
      ovr_d   = 1'b0;
    end else if (win_end) begin
      // the final-cycle event is folded into the reported count
      cnt_d   = evt_nx;
      alarm_d = int'(evt_nx) >= THRESH;
      valid_d = 1'b1;
      ovr_d   = ovr_q || (valid_q && !ACK) || sat_win;
    end else if (valid_q && ACK) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      z_q     <= 1'b0;
      evt_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      alarm_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= Z;
      evt_q   <= evt_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      alarm_q <= alarm_d;
      ovr_q   <= ovr_d;
    end
  end

  assign CNT_OUT = cnt_q;
  assign VALID   = valid_q;
  assign ALARM   = alarm_q;
  assign OVERRUN = ovr_q;
  assign BUSY    = (state_q == RUN);

endmodule

// File: tb/tb_detection_event_monitor.sv
// Scoreboard bench for detection_event_monitor (WINDOW=16, THRESH=3).
// A second CNT_W=2 instance covers counter wrap / saturation.
module tb_detection_event_monitor;

  logic       CLK = 1'b0;
  logic       RESET, Z, EN, CLR, ACK;
  logic [7:0] CNT_OUT;
  logic       VALID, ALARM, OVERRUN, BUSY;
  logic [1:0] cnt_s;
  logic       valid_s, alarm_s, ovr_s, busy_s;

  always #5 CLK = ~CLK;

  detection_event_monitor #(
    .CNT_W(8), .WINDOW(16), .THRESH(3)
  ) dut (
    .CLK(CLK), .RESET(RESET), .Z(Z), .EN(EN), .CLR(CLR), .ACK(ACK),
    .CNT_OUT(CNT_OUT), .VALID(VALID), .ALARM(ALARM),
    .OVERRUN(OVERRUN), .BUSY(BUSY)
  );

  detection_event_monitor #(
    .CNT_W(2), .WINDOW(16), .THRESH(3)
  ) dut_s (
    .CLK(CLK), .RESET(RESET), .Z(Z), .EN(EN), .CLR(CLR), .ACK(ACK),
    .CNT_OUT(cnt_s), .VALID(valid_s), .ALARM(alarm_s),
    .OVERRUN(ovr_s), .BUSY(busy_s)
  );

  typedef struct packed {
    logic [7:0] cnt;
    logic       alarm;
  } exp_t;

  exp_t sb[$];
  int   ntests = 0;
  int   nfail  = 0;
  logic zprev  = 1'b0;
  logic e_valid = 1'b0;
  logic e_ovr   = 1'b0;
  int   e_evt   = 0;
  int   wpos    = 0;
  logic [7:0] last_cnt = '0;

  task automatic cyc(input logic z, input logic ack);
    logic ev;
    logic ended;
    exp_t e;
    Z = z;
    ACK = ack;
    ev = z && !zprev;
    zprev = z;
    ended = 1'b0;
    @(negedge CLK);
    if (wpos == 15) begin
      e.cnt = 8'(e_evt + int'(ev));
      e.alarm = (e_evt + int'(ev)) >= 3;
      sb.push_back(e);
      if (e_valid && !ack) e_ovr = 1'b1;
      e_valid = 1'b1;
      e_evt = 0;
      wpos = 0;
      ended = 1'b1;
    end else begin
      e_evt += int'(ev);
      wpos++;
      if (e_valid && ack) e_valid = 1'b0;
    end
    ntests++;
    if (VALID !== e_valid || OVERRUN !== e_ovr || BUSY !== 1'b1) begin
      nfail++;
      $display("FAIL flags pos%0d: got V%b O%b B%b, want V%b O%b B1",
               wpos, VALID, OVERRUN, BUSY, e_valid, e_ovr);
    end
    if (ended) begin
      ntests++;
      if (sb.size() == 0) begin
        nfail++;
        $display("FAIL scoreboard: empty on window end");
      end else begin
        e = sb.pop_front();
        last_cnt = e.cnt;
        if (CNT_OUT !== e.cnt || ALARM !== e.alarm) begin
          nfail++;
          $display("FAIL result: got cnt %0d alarm %b, want cnt %0d alarm %b",
                   CNT_OUT, ALARM, e.cnt, e.alarm);
        end
      end
    end
  endtask

  task automatic run_window(input logic [15:0] zp, input logic [15:0] am);
    for (int k = 0; k < 16; k++) cyc(zp[k], am[k]);
    ACK = 1'b0;
  endtask

  task automatic start_run();
    EN = 1'b1; Z = 1'b0; zprev = 1'b0; ACK = 1'b0;
    @(negedge CLK);
    wpos = 0; e_evt = 0;
    ntests++;
    if (BUSY !== 1'b1) begin
      nfail++;
      $display("FAIL start busy: got %b, want 1", BUSY);
    end
  endtask

  task automatic clr_cycle(input logic busy_exp);
    CLR = 1'b1; Z = 1'b0; zprev = 1'b0; ACK = 1'b0;
    @(negedge CLK);
    CLR = 1'b0;
    e_valid = 1'b0; e_ovr = 1'b0; e_evt = 0; wpos = 0; last_cnt = '0;
    ntests++;
    if (CNT_OUT !== 8'd0 || VALID !== 1'b0 || ALARM !== 1'b0 ||
        OVERRUN !== 1'b0 || BUSY !== busy_exp) begin
      nfail++;
      $display("FAIL clr: got c%0d V%b A%b O%b B%b, want 0 0 0 0 B%b",
               CNT_OUT, VALID, ALARM, OVERRUN, BUSY, busy_exp);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Z = 1'($urandom); EN = 1'($urandom);
      CLR = 1'($urandom); ACK = 1'($urandom);
      @(negedge CLK);
    end
    ntests++;
    if (CNT_OUT !== 8'd0 || VALID !== 1'b0 || ALARM !== 1'b0 ||
        OVERRUN !== 1'b0 || BUSY !== 1'b0) begin
      nfail++;
      $display("FAIL reset: got c%0d V%b A%b O%b B%b, want all 0",
               CNT_OUT, VALID, ALARM, OVERRUN, BUSY);
    end
    RESET = 1'b1; Z = 1'b0; EN = 1'b0; CLR = 1'b0; ACK = 1'b0;
    zprev = 1'b0;
    @(negedge CLK);
    ntests++;
    if (BUSY !== 1'b0 || VALID !== 1'b0) begin
      nfail++;
      $display("FAIL idle: got B%b V%b, want 0 0", BUSY, VALID);
    end
  endtask

  task automatic test_count();
    start_run();
    run_window(16'h8024, 16'h0000);
    run_window(16'h13F0, 16'h0001);
  endtask

  task automatic test_overrun();
    run_window(16'h0008, 16'h0001);
    run_window(16'h00AA, 16'h0000);
    cyc(1'b0, 1'b1);
    ACK = 1'b0;
    ntests++;
    if (VALID !== 1'b0 || OVERRUN !== 1'b1) begin
      nfail++;
      $display("FAIL ack sticky: got V%b O%b, want V0 O1", VALID, OVERRUN);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 5; i++) cyc(i == 2, 1'b0);
    clr_cycle(1'b1);
  endtask

  task automatic test_back_to_back();
    run_window(16'h0004, 16'h0000);
    run_window(16'h0112, 16'h8000);
  endtask

  task automatic test_disable();
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    ACK = 1'b0;
    EN = 1'b0; Z = 1'b0; zprev = 1'b0;
    @(negedge CLK);
    wpos = 0; e_evt = 0;
    for (int i = 0; i < 20; i++) @(negedge CLK);
    ntests++;
    if (BUSY !== 1'b0 || VALID !== 1'b0 || CNT_OUT !== last_cnt) begin
      nfail++;
      $display("FAIL disable: got B%b V%b c%0d, want B0 V0 c%0d",
               BUSY, VALID, CNT_OUT, last_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_c;
    logic       exp_o, exp_a;
`ifdef DETECTION_MONITOR_SATURATE_EN
    exp_c = 2'd3; exp_o = 1'b1; exp_a = 1'b1;
`else
    exp_c = 2'd1; exp_o = 1'b0; exp_a = 1'b0;
`endif
    clr_cycle(1'b0);
    start_run();
    run_window(16'h02AA, 16'h0000);
    ntests++;
    if (cnt_s !== exp_c || ovr_s !== exp_o || alarm_s !== exp_a ||
        valid_s !== 1'b1 || busy_s !== 1'b1) begin
      nfail++;
      $display("FAIL narrow: got c%0d O%b A%b V%b B%b, want c%0d O%b A%b V1 B1",
               cnt_s, ovr_s, alarm_s, valid_s, busy_s, exp_c, exp_o, exp_a);
    end
  endtask

  initial begin
    RESET = 1'b0; Z = 1'b0; EN = 1'b0; CLR = 1'b0; ACK = 1'b0;
    @(negedge CLK);
    test_reset();
    test_count();
    test_overrun();
    test_clr();
    test_back_to_back();
    test_disable();
    test_saturate();
    ntests++;
    if (sb.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard leftover: got %0d, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
